// File: rtl/jtcontra_cen_gen.sv
// Fractional clock-enable generator: base tick at NUM/DEN of clk, plus binary-divided enables.
// Optional macro JTCONTRA_CEN_RECOVER_EN replays up to 3 ticks withheld by stall or collision.
module jtcontra_cen_gen #(
  parameter int W   = 10,
  parameter int NUM = 1,
  parameter int DEN = 8,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  output logic [DIV-1:0] cen,
  output logic [DIV-2:0] cenb,
  output logic [1:0]     debt
);
  localparam logic [W:0] NUM_W = (W+1)'(NUM);
  localparam logic [W:0] DEN_W = (W+1)'(DEN);

  if (NUM < 1 || NUM >= DEN || longint'(DEN) >= (longint'(1) << W)) begin : g_bad_frac
    $error("jtcontra_cen_gen: parameters must satisfy 1 <= NUM < DEN < 2**W");
  end
  if (DIV < 2 || DIV > 8) begin : g_bad_div
    $error("jtcontra_cen_gen: DIV must be in 2..8");
  end

  logic [W-1:0]   r_acc;
  logic [DIV-1:0] r_dcnt;
  logic [DIV-1:0] r_cen;
  logic [DIV-2:0] r_cenb;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic           w_ovf;
  logic           w_emit;
  logic [W-1:0]   w_acc_nxt;
  logic [DIV-1:0] w_cen;
  logic [DIV-2:0] w_cenb;

  assign w_sum     = {1'b0, r_acc} + NUM_W;
  assign w_diff    = w_sum - DEN_W;
  assign w_ovf     = (w_sum >= DEN_W);
  assign w_acc_nxt = w_ovf ? w_diff[W-1:0] : w_sum[W-1:0];

  // Enable pattern for the tick about to be emitted, from dcnt before its increment.
  always_comb begin
    w_cen    = '0;
    w_cenb   = '0;
    w_cen[0] = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      w_cen[k]    = ((r_dcnt & ((DIV'(1) << k) - DIV'(1))) == '0);
      w_cenb[k-1] = ((r_dcnt & ((DIV'(1) << k) - DIV'(1))) == (DIV'(1) << (k - 1)));
    end
  end

`ifdef JTCONTRA_CEN_RECOVER_EN
  logic [1:0] r_debt;
  logic       w_replay;
  logic       w_defer;

  // r_cen[0] marks an emitted tick last cycle; enables are never back to back.
  always_comb begin
    w_emit   = 1'b0;
    w_replay = 1'b0;
    if (!stall && !r_cen[0]) begin
      if (w_ovf) begin
        w_emit = 1'b1;
      end else if (r_debt != 2'd0) begin
        w_emit   = 1'b1;
        w_replay = 1'b1;
      end
    end
  end

  assign w_defer = w_ovf && !w_emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_debt <= 2'd0;
    end else if (w_defer) begin
      if (r_debt != 2'd3) r_debt <= r_debt + 2'd1;
    end else if (w_replay) begin
      r_debt <= r_debt - 2'd1;
    end
  end

  assign debt = r_debt;
`else
  assign w_emit = w_ovf && !stall && !r_cen[0];
  assign debt   = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_dcnt <= '0;
      r_cen  <= '0;
      r_cenb <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_cen  <= w_emit ? w_cen : '0;
      r_cenb <= w_emit ? w_cenb : '0;
      if (w_emit) r_dcnt <= r_dcnt + DIV'(1);
    end
  end

  assign cen  = r_cen;
  assign cenb = r_cenb;

endmodule
